// File: rtl/parity_frame_checker_if.sv
// Purpose : bundle of the serial receive pin and the received-word status outputs.
// Latency : n/a (wires only).
// Backpressure: none; valid is a one-cycle pulse with no ready handshake.
// Ports   : D (serial line in, idle high), Q (received word), valid (update pulse),
//           parity_err / frame_err (status of last frame), busy (receiver not idle).
interface parity_frame_checker_if #(
    parameter int WIDTH = 8
);
    logic             D;
    logic [WIDTH-1:0] Q;
    logic             valid;
    logic             parity_err;
    logic             frame_err;
    logic             busy;

    // master: drives the line and observes results (line driver / bench)
    modport master (
        output D,
        input  Q, valid, parity_err, frame_err, busy
    );

    // slave: the receiver itself
    modport slave (
        input  D,
        output Q, valid, parity_err, frame_err, busy
    );
endinterface

// File: rtl/parity_frame_checker.sv
// Purpose : deserialise a start/data/parity/stop framed bit stream, check parity and stop bit.
// Latency : stop bit sampled (WIDTH+2)*BIT_CYCLES + BIT_CYCLES/2 edges after start seen; valid one cycle later.
// Backpressure: none; Q and error flags hold until the next frame's stop sample.
// Ports   : clock, reset (async active-high), bus.slave (D in; Q, valid, parity_err, frame_err, busy out).
module parity_frame_checker #(
    parameter int WIDTH      = 8,
    parameter int BIT_CYCLES = 4,
    parameter bit ODD        = 1'b0
) (
    input  logic                  clock,
    input  logic                  reset,
    parity_frame_checker_if.slave bus
);

    localparam int CW = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t           state_q,  state_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [IW-1:0]    bitidx_q, bitidx_d;
    logic [WIDTH-1:0] shreg_q,  shreg_d;
    logic             p_q,      p_d;
    logic [WIDTH-1:0] word_q,   word_d;
    logic             valid_q,  valid_d;
    logic             perr_q,   perr_d;
    logic             ferr_q,   ferr_d;

    logic sample;
    logic wrap;

    assign sample = (cnt_q == CW'(BIT_CYCLES / 2));
    assign wrap   = (cnt_q == CW'(BIT_CYCLES - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bitidx_q <= '0;
            shreg_q  <= '0;
            p_q      <= 1'b0;
            word_q   <= '0;
            valid_q  <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bitidx_q <= bitidx_d;
            shreg_q  <= shreg_d;
            p_q      <= p_d;
            word_q   <= word_d;
            valid_q  <= valid_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = wrap ? '0 : cnt_q + CW'(1);
        bitidx_d = bitidx_q;
        shreg_d  = shreg_q;
        p_d      = p_q;
        word_d   = word_q;
        valid_d  = 1'b0;
        perr_d   = perr_q;
        ferr_d   = ferr_q;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!bus.D) begin
                    // the edge that sees the low line is already cnt 0 of the start bit
                    state_d = S_START;
                    cnt_d   = CW'(1);
                end
            end
            S_START: begin
                if (sample && bus.D) begin
                    // line back high mid start bit: glitch, drop it silently
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (wrap) begin
                    state_d  = S_DATA;
                    bitidx_d = '0;
                end
            end
            S_DATA: begin
                if (sample) begin
                    shreg_d[bitidx_q] = bus.D;
                end
                if (wrap) begin
                    if (bitidx_q == IW'(WIDTH - 1)) begin
                        state_d = S_PARITY;
                    end else begin
                        bitidx_d = bitidx_q + IW'(1);
                    end
                end
            end
            S_PARITY: begin
                if (sample) begin
                    p_d = bus.D;
                end
                if (wrap) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                // frame completes at the stop sample point; the rest of the stop
                // bit is not waited for so a back-to-back start is never missed
                if (sample) begin
                    word_d  = shreg_q;
                    perr_d  = (^{shreg_q, p_q}) ^ ODD;
                    ferr_d  = ~bus.D;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = bus.D ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: begin
                // a low stop bit must not be mistaken for the next start bit
                cnt_d = '0;
                if (bus.D) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.Q          = word_q;
    assign bus.valid      = valid_q;
    assign bus.parity_err = perr_q;
    assign bus.frame_err  = ferr_q;
    assign bus.busy       = (state_q != S_IDLE);

endmodule
